// File: rtl/uart_tx_frame.sv
// Serial frame transmitter: start, DATA_BITS LSB first, optional parity, 1-2 stop bits, baud from clk.
// Latency: txd falls at the acceptance edge; done pulses F cycles later, together with avail.
// Backpressure: avail low while busy; requests are dropped, not queued. UART_TX_BREAK_EN adds brk.
module uart_tx_frame #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 1,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 send,
`ifdef UART_TX_BREAK_EN
    input  logic                 brk,
`endif
    output logic                 txd,
    output logic                 avail,
    output logic                 done
);

    localparam int IDX_W = $clog2(DATA_BITS + 1);
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD    = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_DATA_LAST = IDX_W'(DATA_BITS);
    localparam logic [IDX_W-1:0] IDX_STOP_LAST = IDX_W'(STOP_BITS);
    localparam logic             PARITY_INV    = (PARITY_MODE == 2);

    if (STOP_BITS < 1 || STOP_BITS > 2 || PARITY_MODE < 0 || PARITY_MODE > 2 ||
        DATA_BITS < 5 || DATA_BITS > 9 || CLKS_PER_BIT < 1) begin : g_param_check
        $error("uart_tx_frame: illegal parameter value");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BRK,
        S_BRK_MARK
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_q, par_d;
    logic                 send_hist_q, send_hist_d;
    logic                 txd_q, txd_d;
    logic                 avail_q, avail_d;
    logic                 done_q, done_d;
    logic                 bit_end;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shreg_d     = shreg_q;
        par_d       = par_q;
        txd_d       = txd_q;
        avail_d     = avail_q;
        done_d      = 1'b0;
        send_hist_d = send;
        bit_end     = (cnt_q == '0);

        if (state_q inside {S_START, S_DATA, S_PARITY, S_STOP}) begin
            cnt_d = bit_end ? CNT_RELOAD : cnt_q - CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
`ifdef UART_TX_BREAK_EN
                if (brk) begin
                    state_d = S_BRK;
                    txd_d   = 1'b0;
                    avail_d = 1'b0;
                end else
`endif
                if (send && !send_hist_q) begin
                    state_d = S_START;
                    shreg_d = data;
                    par_d   = (^data) ^ PARITY_INV;
                    cnt_d   = CNT_RELOAD;
                    idx_d   = '0;
                    txd_d   = 1'b0;
                    avail_d = 1'b0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    txd_d   = shreg_q[0];
                    shreg_d = shreg_q >> 1;
                    idx_d   = IDX_W'(1);
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (idx_q == IDX_DATA_LAST) begin
                        if (PARITY_MODE != 0) begin
                            state_d = S_PARITY;
                            txd_d   = par_q;
                        end else begin
                            state_d = S_STOP;
                            txd_d   = 1'b1;
                            idx_d   = IDX_W'(1);
                        end
                    end else begin
                        txd_d   = shreg_q[0];
                        shreg_d = shreg_q >> 1;
                        idx_d   = idx_q + IDX_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    txd_d   = 1'b1;
                    idx_d   = IDX_W'(1);
                end
            end
            S_STOP: begin
                // idx counts stop bits here; the last one returns to idle
                if (bit_end) begin
                    if (idx_q == IDX_STOP_LAST) begin
                        state_d = S_IDLE;
                        avail_d = 1'b1;
                        done_d  = 1'b1;
                        idx_d   = '0;
                        cnt_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
`ifdef UART_TX_BREAK_EN
            S_BRK: begin
                if (!brk) begin
                    state_d = S_BRK_MARK;
                    txd_d   = 1'b1;
                end
            end
            S_BRK_MARK: begin
                state_d = S_IDLE;
                avail_d = 1'b1;
            end
`endif
            default: begin
                state_d = S_IDLE;
                txd_d   = 1'b1;
                avail_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shreg_q     <= '0;
            par_q       <= 1'b0;
            send_hist_q <= 1'b1;
            txd_q       <= 1'b1;
            avail_q     <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shreg_q     <= shreg_d;
            par_q       <= par_d;
            send_hist_q <= send_hist_d;
            txd_q       <= txd_d;
            avail_q     <= avail_d;
            done_q      <= done_d;
        end
    end

    assign txd   = txd_q;
    assign avail = avail_q;
    assign done  = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: default 8N1, even/odd parity, slow baud with two stop bits.
module tb_uart_tx_frame;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] data0, data1, data3;
    logic       send0, send1, send3;
    logic       txd0, avail0, done0;
    logic       txd1, avail1, done1;
    logic       txd2, avail2, done2;
    logic       txd3, avail3, done3;
`ifdef UART_TX_BREAK_EN
    logic       brk0;
`endif

    int checks   = 0;
    int failures = 0;
    int frames;
    int dones;
    logic prev_avail;

    // Frame images, bit 0 = first bit on the line
    logic [9:0]  exp_a5   = 10'b1101001010;
    logic [9:0]  exp_5a   = 10'b1010110100;
    logic [10:0] exp_even = 11'b11000001110;
    logic [10:0] exp_odd  = 11'b10000001110;

    uart_tx_frame u0 (
        .clk(clk), .rst(rst), .data(data0), .send(send0),
`ifdef UART_TX_BREAK_EN
        .brk(brk0),
`endif
        .txd(txd0), .avail(avail0), .done(done0)
    );

    uart_tx_frame #(.PARITY_MODE(1)) u1 (
        .clk(clk), .rst(rst), .data(data1), .send(send1),
`ifdef UART_TX_BREAK_EN
        .brk(1'b0),
`endif
        .txd(txd1), .avail(avail1), .done(done1)
    );

    uart_tx_frame #(.PARITY_MODE(2)) u2 (
        .clk(clk), .rst(rst), .data(data1), .send(send1),
`ifdef UART_TX_BREAK_EN
        .brk(1'b0),
`endif
        .txd(txd2), .avail(avail2), .done(done2)
    );

    uart_tx_frame #(.CLKS_PER_BIT(4), .STOP_BITS(2)) u3 (
        .clk(clk), .rst(rst), .data(data3), .send(send3),
`ifdef UART_TX_BREAK_EN
        .brk(1'b0),
`endif
        .txd(txd3), .avail(avail3), .done(done3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst   = 1'b1;
        send0 = 1'b1;
        send1 = 1'b0;
        send3 = 1'b0;
        data0 = 8'h00;
        data1 = 8'h00;
        data3 = 8'h00;
`ifdef UART_TX_BREAK_EN
        brk0  = 1'b0;
`endif
        repeat (3) tick();
        check("rst_txd",   32'(txd0),   32'(1));
        check("rst_avail", 32'(avail0), 32'(1));
        check("rst_done",  32'(done0),  32'(0));
        check("rst_avail3", 32'(avail3), 32'(1));

        // send held high through reset must not start a frame
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("held_send_avail[%0d]", i), 32'(avail0), 32'(1));
        end
        send0 = 1'b0;
        tick();

        // Default 8N1 frame of 0xA5; data changed after acceptance must not matter
        data0 = 8'hA5;
        send0 = 1'b1;
        tick();
        data0 = 8'hFF;
        send0 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("t1_txd[%0d]", i),   32'(txd0),   32'(exp_a5[i]));
            check($sformatf("t1_avail[%0d]", i), 32'(avail0), 32'(0));
            check($sformatf("t1_done[%0d]", i),  32'(done0),  32'(0));
            tick();
        end
        check("t1_end_avail", 32'(avail0), 32'(1));
        check("t1_end_done",  32'(done0),  32'(1));
        check("t1_end_txd",   32'(txd0),   32'(1));
        tick();
        check("t1_done_once", 32'(done0), 32'(0));

        // Even and odd parity of 0x07
        data1 = 8'h07;
        send1 = 1'b1;
        tick();
        send1 = 1'b0;
        for (int i = 0; i < 11; i++) begin
            check($sformatf("t2_even_txd[%0d]", i), 32'(txd1),   32'(exp_even[i]));
            check($sformatf("t2_odd_txd[%0d]", i),  32'(txd2),   32'(exp_odd[i]));
            check($sformatf("t2_avail[%0d]", i),    32'(avail1), 32'(0));
            tick();
        end
        check("t2_even_done", 32'(done1),  32'(1));
        check("t2_odd_done",  32'(done2),  32'(1));
        check("t2_avail_end", 32'(avail2), 32'(1));

        // CLKS_PER_BIT=4, two stop bits, all-zero payload
        data3 = 8'h00;
        send3 = 1'b1;
        tick();
        send3 = 1'b0;
        for (int i = 0; i < 44; i++) begin
            check($sformatf("t3_txd[%0d]", i),   32'(txd3),   32'(i >= 36 ? 1 : 0));
            check($sformatf("t3_avail[%0d]", i), 32'(avail3), 32'(0));
            tick();
        end
        check("t3_done",  32'(done3),  32'(1));
        check("t3_avail", 32'(avail3), 32'(1));
        tick();

        // send held high for 30 cycles
        data0 = 8'h3C;
        frames = 0; dones = 0; prev_avail = avail0;
        send0 = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (prev_avail && !avail0) frames++;
            if (done0) dones++;
            prev_avail = avail0;
        end
        send0 = 1'b0;
        tick();
        check("t4a_frames", 32'(frames), 32'(1));
        check("t4a_dones",  32'(dones),  32'(1));

        // second rise at cycle 5 while busy
        frames = 0; dones = 0; prev_avail = avail0;
        for (int i = 0; i < 40; i++) begin
            send0 = (i < 2) || (i >= 5 && i < 25);
            tick();
            if (prev_avail && !avail0) frames++;
            if (done0) dones++;
            prev_avail = avail0;
        end
        check("t4b_frames", 32'(frames), 32'(1));
        check("t4b_dones",  32'(dones),  32'(1));

        // rise sampled on the same edge that avail returns
        frames = 0; dones = 0; prev_avail = avail0;
        for (int i = 0; i < 40; i++) begin
            send0 = (i < 2) || (i >= 10 && i < 20);
            tick();
            if (prev_avail && !avail0) frames++;
            if (done0) dones++;
            prev_avail = avail0;
        end
        check("t4c_frames", 32'(frames), 32'(1));
        check("t4c_dones",  32'(dones),  32'(1));

        // reset at cycle 4 of a frame, then a clean frame
        data0 = 8'h00;
        send0 = 1'b1;
        tick();
        send0 = 1'b0;
        repeat (4) tick();
        check("t5_mid_txd",   32'(txd0),   32'(0));
        check("t5_mid_avail", 32'(avail0), 32'(0));
        rst = 1'b1;
        tick();
        check("t5_rst_txd",   32'(txd0),   32'(1));
        check("t5_rst_avail", 32'(avail0), 32'(1));
        check("t5_rst_done",  32'(done0),  32'(0));
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done0) dones++;
        end
        check("t5_no_done",    32'(dones),  32'(0));
        check("t5_idle_avail", 32'(avail0), 32'(1));
        data0 = 8'h5A;
        send0 = 1'b1;
        tick();
        send0 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("t5_txd[%0d]", i), 32'(txd0), 32'(exp_5a[i]));
            tick();
        end
        check("t5_done",  32'(done0),  32'(1));
        check("t5_avail", 32'(avail0), 32'(1));

`ifdef UART_TX_BREAK_EN
        tick();
        brk0 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check($sformatf("t6_brk_txd[%0d]", i),   32'(txd0),   32'(0));
            check($sformatf("t6_brk_avail[%0d]", i), 32'(avail0), 32'(0));
        end
        brk0 = 1'b0;
        tick();
        check("t6_mark_txd",   32'(txd0),   32'(1));
        check("t6_mark_avail", 32'(avail0), 32'(0));
        tick();
        check("t6_ready_avail", 32'(avail0), 32'(1));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
